// File: rtl/multi_window_timer.sv
// N-channel start/stop window timer with per-channel captured min/max bounds.
// Optional build macro MULTI_WINDOW_TIMER_RETRIGGER_EN: start during RUN restarts the run.
module multi_window_timer #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH-1:0]       abort,
  input  logic [CNT_W-1:0]      t_min,
  input  logic [CNT_W-1:0]      t_max,
  output logic [N_CH-1:0]       active,
  output logic [N_CH-1:0]       done,
  output logic [2*N_CH-1:0]     status,
  output logic [CNT_W*N_CH-1:0] measured
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] ST_OK      = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   mn;
    logic [CNT_W-1:0]   mx;
    logic               act_q;
    logic               done_q;
    logic [1:0]         st_q;
    logic [CNT_W-1:0]   meas_q;
    logic               timeout;
    logic               accept;

    // Termination conditions evaluated on the pre-edge count.
    always_comb begin
      timeout = (cnt >= mx);
      accept  = stop[i] && (cnt >= mn);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state  <= IDLE;
        cnt    <= '0;
        mn     <= '0;
        mx     <= '0;
        act_q  <= 1'b0;
        done_q <= 1'b0;
        st_q   <= 2'b00;
        meas_q <= '0;
      end else begin
        done_q <= 1'b0;
        case (state)
          IDLE: begin
            if (start[i]) begin
              state <= RUN;
              act_q <= 1'b1;
              cnt   <= '0;
              mn    <= t_min;
              mx    <= t_max;
            end
          end
          RUN: begin
            if (abort[i]) begin
              state  <= IDLE;
              act_q  <= 1'b0;
              done_q <= 1'b1;
              st_q   <= ST_ABORT;
              meas_q <= cnt;
            end else if (timeout || accept) begin
              done_q <= 1'b1;
              st_q   <= timeout ? ST_TIMEOUT : ST_OK;
              meas_q <= cnt;
              // A coincident start chains straight into a fresh run.
              if (start[i]) begin
                cnt <= '0;
                mn  <= t_min;
                mx  <= t_max;
              end else begin
                state <= IDLE;
                act_q <= 1'b0;
              end
`ifdef MULTI_WINDOW_TIMER_RETRIGGER_EN
            end else if (start[i]) begin
              cnt <= '0;
              mn  <= t_min;
              mx  <= t_max;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign active[i]                 = act_q;
    assign done[i]                   = done_q;
    assign status[2*i +: 2]          = st_q;
    assign measured[CNT_W*i +: CNT_W] = meas_q;
  end

endmodule

// File: tb/tb_multi_window_timer.sv
// Directed self-checking bench for multi_window_timer (4 channels, 16-bit counters).
module tb_multi_window_timer;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 16;

  logic                  clk;
  logic                  reset;
  logic [N_CH-1:0]       start;
  logic [N_CH-1:0]       stop;
  logic [N_CH-1:0]       abort;
  logic [CNT_W-1:0]      t_min;
  logic [CNT_W-1:0]      t_max;
  logic [N_CH-1:0]       active;
  logic [N_CH-1:0]       done;
  logic [2*N_CH-1:0]     status;
  logic [CNT_W*N_CH-1:0] measured;

  int n_checks;
  int n_pass;

  multi_window_timer #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .abort(abort),
    .t_min(t_min), .t_max(t_max), .active(active), .done(done),
    .status(status), .measured(measured)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] st(input int ch);
    return status[2*ch +: 2];
  endfunction

  function automatic logic [CNT_W-1:0] meas(input int ch);
    return measured[CNT_W*ch +: CNT_W];
  endfunction

  // Steps until done[ch] rises; n = edges taken, or -1 if the budget expires.
  task automatic wait_done(input int ch, input int max_steps, output int n);
    n = -1;
    for (int k = 1; k <= max_steps; k++) begin
      step();
      if (done[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  int n;
  int done_edge[N_CH];
  logic [CNT_W-1:0] tmax_tab[N_CH];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    start = '0; stop = '0; abort = '0;
    t_min = '0; t_max = '0;
    tmax_tab[0] = 16'd10; tmax_tab[1] = 16'd13; tmax_tab[2] = 16'd7; tmax_tab[3] = 16'd20;
    for (int c = 0; c < int'(N_CH); c++) done_edge[c] = -1;
    step(); step();
    check("rst_active", 64'(active), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_measured", 64'(measured), 64'd0);
    reset = 1'b0;
    step();

    // Plain timeout on ch0.
    t_min = 16'd20; t_max = 16'd40;
    start[0] = 1'b1; step(); start[0] = 1'b0;
    check("to_active_after_start", 64'(active[0]), 64'd1);
    wait_done(0, 60, n);
    check("to_active_cycles", 64'(n), 64'd41);
    check("to_active_fall", 64'(active[0]), 64'd0);
    check("to_status", 64'(st(0)), 64'd2);
    check("to_measured", 64'(meas(0)), 64'd40);
    step();
    check("to_done_one_cycle", 64'(done[0]), 64'd0);
    check("to_status_hold", 64'(st(0)), 64'd2);

    // Early stop ignored until count reaches t_min.
    start[0] = 1'b1; step(); start[0] = 1'b0;
    for (int k = 0; k < 5; k++) step();
    stop[0] = 1'b1;
    wait_done(0, 60, n);
    stop[0] = 1'b0;
    check("ok_edges", 64'(n), 64'd16);
    check("ok_status", 64'(st(0)), 64'd1);
    check("ok_measured", 64'(meas(0)), 64'd20);
    check("ok_active", 64'(active[0]), 64'd0);

    // Abort with stop and start on the same edge.
    start[1] = 1'b1; step(); start[1] = 1'b0;
    for (int k = 0; k < 30; k++) step();
    abort[1] = 1'b1; stop[1] = 1'b1; start[1] = 1'b1;
    step();
    abort[1] = 1'b0; stop[1] = 1'b0; start[1] = 1'b0;
    check("ab_done", 64'(done[1]), 64'd1);
    check("ab_status", 64'(st(1)), 64'd3);
    check("ab_measured", 64'(meas(1)), 64'd30);
    check("ab_active", 64'(active[1]), 64'd0);
    step();
    check("ab_stays_idle", 64'(active[1]), 64'd0);

    // Staggered starts with bounds changed between them.
    t_min = '0;
    for (int k = 0; k < 30; k++) begin
      start = '0;
      if (k < int'(N_CH)) begin
        start[k] = 1'b1;
        t_max = tmax_tab[k];
      end
      step();
      for (int c = 0; c < int'(N_CH); c++)
        if (done[c]) begin
          done_edge[c] = k;
          check($sformatf("stag_meas%0d", c), 64'(meas(c)), 64'(tmax_tab[c]));
        end
    end
    start = '0;
    check("stag_edge0", 64'(done_edge[0]), 64'd11);
    check("stag_edge1", 64'(done_edge[1]), 64'd15);
    check("stag_edge2", 64'(done_edge[2]), 64'd10);
    check("stag_edge3", 64'(done_edge[3]), 64'd24);
    check("stag_status", 64'(status), 64'hAA);

    // Stop accepted with a coincident start chains into a new run.
    t_min = 16'd20; t_max = 16'd40;
    start[2] = 1'b1; step(); start[2] = 1'b0;
    for (int k = 0; k < 25; k++) step();
    stop[2] = 1'b1; start[2] = 1'b1;
    step();
    stop[2] = 1'b0; start[2] = 1'b0;
    check("chain_done", 64'(done[2]), 64'd1);
    check("chain_status", 64'(st(2)), 64'd1);
    check("chain_measured", 64'(meas(2)), 64'd25);
    check("chain_active", 64'(active[2]), 64'd1);
    wait_done(2, 60, n);
    check("chain_restart_edges", 64'(n), 64'd41);
    check("chain_to_measured", 64'(meas(2)), 64'd40);

    // Start in RUN without termination.
    start[3] = 1'b1; step(); start[3] = 1'b0;
    for (int k = 0; k < 10; k++) step();
    start[3] = 1'b1; step(); start[3] = 1'b0;
    check("retrig_no_done", 64'(done[3]), 64'd0);
    check("retrig_active", 64'(active[3]), 64'd1);
    check("retrig_status_hold", 64'(st(3)), 64'd2);
    check("retrig_meas_hold", 64'(meas(3)), 64'd20);
    wait_done(3, 60, n);
`ifdef MULTI_WINDOW_TIMER_RETRIGGER_EN
    check("retrig_edges", 64'(n), 64'd41);
`else
    check("retrig_edges", 64'(n), 64'd30);
`endif
    check("retrig_measured", 64'(meas(3)), 64'd40);

    // Asynchronous reset mid-run.
    start[0] = 1'b1; step(); start[0] = 1'b0;
    for (int k = 0; k < 15; k++) step();
    #2 reset = 1'b1;
    #1;
    check("arst_active", 64'(active), 64'd0);
    check("arst_status", 64'(status), 64'd0);
    check("arst_measured", 64'(measured), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    #2 reset = 1'b0;
    step();
    check("arst_no_done", 64'(done), 64'd0);

    // Zero t_max times out on the first RUN edge.
    t_max = '0;
    start[0] = 1'b1; step(); start[0] = 1'b0;
    check("zero_active", 64'(active[0]), 64'd1);
    step();
    check("zero_done", 64'(done[0]), 64'd1);
    check("zero_status", 64'(st(0)), 64'd2);
    check("zero_measured", 64'(meas(0)), 64'd0);
    check("zero_active_fall", 64'(active[0]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
